// File: rtl/serial_uart_bridge.sv
// serial_uart_bridge: joins the processor's byte-wide serial ports to an 8N1 UART line.
// The RX path is a synchroniser, a deserialiser FSM and a first-word-fall-through FIFO.
// The TX path is a FIFO drained by a serialiser FSM that can send frames back-to-back.
module serial_uart_bridge #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       uart_rx_in,
    output logic       uart_tx_out,
    output logic [7:0] rx_data_out,
    output logic       rx_valid_out,
    input  logic       rx_rden_in,
    input  logic [7:0] tx_data_in,
    input  logic       tx_wren_in,
    output logic       tx_ready_out,
    input  logic       err_clear_in,
    output logic       rx_overrun_out,
    output logic       frame_err_out
);
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [CW-1:0]      BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]      HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]      CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [FIFO_AW:0]   PTR_ONE   = {{FIFO_AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // ---------------- RX path ----------------
    logic              rx_meta_r, rx_sync_r;
    uart_state_t       rx_state_r, rx_state_s;
    logic [CW-1:0]     rx_cnt_r, rx_cnt_s;
    logic [2:0]        rx_bit_r, rx_bit_s;
    logic [7:0]        rx_shift_r, rx_shift_s;
    logic              rx_push_s, frame_set_s;
    logic [FIFO_AW:0]  rx_wr_ptr_r, rx_rd_ptr_r;
    logic [7:0]        rx_mem_r [DEPTH];
    logic              rx_empty_s, rx_full_s, rx_pop_s, rx_wr_s, overrun_set_s;

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= uart_rx_in;
            rx_sync_r <= rx_meta_r;
        end
    end

    // RX FSM state and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_state_r <= ST_IDLE;
            rx_cnt_r   <= '0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
        end else begin
            rx_state_r <= rx_state_s;
            rx_cnt_r   <= rx_cnt_s;
            rx_bit_r   <= rx_bit_s;
            rx_shift_r <= rx_shift_s;
        end
    end

    // RX next state: mid-bit sampling, glitch rejection on the start bit, stop-bit check.
    always_comb begin
        rx_state_s  = rx_state_r;
        rx_cnt_s    = rx_cnt_r;
        rx_bit_s    = rx_bit_r;
        rx_shift_s  = rx_shift_r;
        rx_push_s   = 1'b0;
        frame_set_s = 1'b0;
        case (rx_state_r)
            ST_IDLE: begin
                if (!rx_sync_r) begin
                    rx_state_s = ST_START;
                    rx_cnt_s   = '0;
                end else begin
                    rx_cnt_s   = '0;
                end
            end
            ST_START: begin
                if (rx_cnt_r == HALF_LAST) begin
                    rx_cnt_s = '0;
                    rx_bit_s = 3'd0;
                    if (!rx_sync_r) begin
                        rx_state_s = ST_DATA;
                    end else begin
                        rx_state_s = ST_IDLE;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_s   = '0;
                    rx_shift_s = {rx_sync_r, rx_shift_r[7:1]};
                    if (rx_bit_r == 3'd7) begin
                        rx_state_s = ST_STOP;
                    end else begin
                        rx_bit_s = rx_bit_r + 3'd1;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_s   = '0;
                    rx_state_s = ST_IDLE;
                    if (rx_sync_r) begin
                        rx_push_s = 1'b1;
                    end else begin
                        frame_set_s = 1'b1;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + CNT_ONE;
                end
            end
            default: begin
                rx_state_s = ST_IDLE;
                rx_cnt_s   = '0;
            end
        endcase
    end

    assign rx_empty_s    = (rx_wr_ptr_r == rx_rd_ptr_r);
    assign rx_full_s     = (rx_wr_ptr_r[FIFO_AW] != rx_rd_ptr_r[FIFO_AW]) &&
                           (rx_wr_ptr_r[FIFO_AW-1:0] == rx_rd_ptr_r[FIFO_AW-1:0]);
    assign rx_pop_s      = rx_rden_in && !rx_empty_s;
    assign rx_wr_s       = rx_push_s && (!rx_full_s || rx_pop_s);
    assign overrun_set_s = rx_push_s && rx_full_s && !rx_pop_s;
    assign rx_valid_out  = !rx_empty_s;
    assign rx_data_out   = rx_empty_s ? 8'h00 : rx_mem_r[rx_rd_ptr_r[FIFO_AW-1:0]];

    // RX FIFO pointers; the extra MSB tells full from empty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_wr_ptr_r <= '0;
            rx_rd_ptr_r <= '0;
        end else begin
            if (rx_wr_s) rx_wr_ptr_r <= rx_wr_ptr_r + PTR_ONE;
            if (rx_pop_s) rx_rd_ptr_r <= rx_rd_ptr_r + PTR_ONE;
        end
    end

    // RX FIFO storage; contents are only observable through a valid head.
    always_ff @(posedge clock) begin
        if (rx_wr_s) rx_mem_r[rx_wr_ptr_r[FIFO_AW-1:0]] <= rx_shift_r;
    end

    // Sticky error flags; a clear wins over a same-cycle set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_overrun_out <= 1'b0;
            frame_err_out  <= 1'b0;
        end else if (err_clear_in) begin
            rx_overrun_out <= 1'b0;
            frame_err_out  <= 1'b0;
        end else begin
            if (overrun_set_s) rx_overrun_out <= 1'b1;
            if (frame_set_s)   frame_err_out  <= 1'b1;
        end
    end

    // ---------------- TX path ----------------
    logic [FIFO_AW:0]  tx_wr_ptr_r, tx_rd_ptr_r;
    logic [7:0]        tx_mem_r [DEPTH];
    logic              tx_empty_s, tx_full_s, tx_pop_s, tx_wr_s;
    logic [7:0]        tx_head_s;
    uart_state_t       tx_state_r, tx_state_s;
    logic [CW-1:0]     tx_cnt_r, tx_cnt_s;
    logic [2:0]        tx_bit_r, tx_bit_s;
    logic [7:0]        tx_shift_r, tx_shift_s;
    logic              tx_line_r, tx_line_s;

    assign tx_empty_s   = (tx_wr_ptr_r == tx_rd_ptr_r);
    assign tx_full_s    = (tx_wr_ptr_r[FIFO_AW] != tx_rd_ptr_r[FIFO_AW]) &&
                          (tx_wr_ptr_r[FIFO_AW-1:0] == tx_rd_ptr_r[FIFO_AW-1:0]);
    assign tx_wr_s      = tx_wren_in && (!tx_full_s || tx_pop_s);
    assign tx_head_s    = tx_mem_r[tx_rd_ptr_r[FIFO_AW-1:0]];
    assign tx_ready_out = !tx_full_s;
    assign uart_tx_out  = tx_line_r;

    // TX FIFO pointers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_wr_ptr_r <= '0;
            tx_rd_ptr_r <= '0;
        end else begin
            if (tx_wr_s)  tx_wr_ptr_r <= tx_wr_ptr_r + PTR_ONE;
            if (tx_pop_s) tx_rd_ptr_r <= tx_rd_ptr_r + PTR_ONE;
        end
    end

    // TX FIFO storage.
    always_ff @(posedge clock) begin
        if (tx_wr_s) tx_mem_r[tx_wr_ptr_r[FIFO_AW-1:0]] <= tx_data_in;
    end

    // TX FSM state, shifter and the registered line driver.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state_r <= ST_IDLE;
            tx_cnt_r   <= '0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            tx_line_r  <= 1'b1;
        end else begin
            tx_state_r <= tx_state_s;
            tx_cnt_r   <= tx_cnt_s;
            tx_bit_r   <= tx_bit_s;
            tx_shift_r <= tx_shift_s;
            tx_line_r  <= tx_line_s;
        end
    end

    // TX next state: the line value for each bit is set on the edge that starts it.
    always_comb begin
        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_cnt_r;
        tx_bit_s   = tx_bit_r;
        tx_shift_s = tx_shift_r;
        tx_line_s  = tx_line_r;
        tx_pop_s   = 1'b0;
        case (tx_state_r)
            ST_IDLE: begin
                tx_cnt_s = '0;
                if (!tx_empty_s) begin
                    tx_pop_s   = 1'b1;
                    tx_shift_s = tx_head_s;
                    tx_line_s  = 1'b0;
                    tx_state_s = ST_START;
                end else begin
                    tx_line_s  = 1'b1;
                end
            end
            ST_START: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_s   = '0;
                    tx_bit_s   = 3'd0;
                    tx_line_s  = tx_shift_r[0];
                    tx_state_s = ST_DATA;
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_s = '0;
                    if (tx_bit_r == 3'd7) begin
                        tx_line_s  = 1'b1;
                        tx_state_s = ST_STOP;
                    end else begin
                        tx_bit_s   = tx_bit_r + 3'd1;
                        tx_line_s  = tx_shift_r[1];
                        tx_shift_s = {1'b0, tx_shift_r[7:1]};
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_s = '0;
                    if (!tx_empty_s) begin
                        tx_pop_s   = 1'b1;
                        tx_shift_s = tx_head_s;
                        tx_line_s  = 1'b0;
                        tx_state_s = ST_START;
                    end else begin
                        tx_state_s = ST_IDLE;
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            default: begin
                tx_state_s = ST_IDLE;
                tx_line_s  = 1'b1;
            end
        endcase
    end

endmodule
